// File: rtl/param_fetch_pkg.sv
// Shared types and constants for the parameter-SRAM read engine.
package param_fetch_pkg;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/param_fetch_fifo.sv
// Two-entry FIFO whose head register drives the stream output directly.
module param_fetch_fifo
  import param_fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_cnt
);
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_cnt;
  logic              w_pop;

  assign w_pop   = i_pop && (r_cnt != 2'd0);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_head;
  assign o_cnt   = r_cnt;

  // Push into a full FIFO is only legal alongside a pop; the tail shifts to head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= i_din;
          else               r_tail <= i_din;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/param_fetch.sv
// Sequential SRAM read engine: issues len reads from base_addr and streams them out.
module param_fetch
  import param_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_W_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_W_data,
  input  logic [DATA_W-1:0] mem_R_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  state_e            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_sent;
  logic              r_inflight;
  logic              r_done;

  logic              w_pop;
  logic              w_issue;
  logic [1:0]        w_fcnt;
  logic [1:0]        w_occ;
  logic              w_fvalid;
  logic [DATA_W-1:0] w_fdata;

  assign w_pop = w_fvalid && out_ready;
  // Credit: a read in flight already owns a FIFO slot; a pop this cycle frees one.
  assign w_occ   = w_fcnt + {1'b0, r_inflight};
  assign w_issue = (r_state == S_FETCH) && (r_issued < r_len) &&
                   ((w_occ < 2'(FIFO_DEPTH)) || w_pop);

  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign mem_cs     = w_issue;
  assign mem_oe     = busy;
  assign mem_W_req  = 1'b1;
  assign mem_W_data = '0;
  assign mem_addr   = w_issue ? (r_base + ADDR_W'(r_issued)) : '0;
  assign out_valid  = w_fvalid;
  assign out_data   = w_fdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_sent     <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (busy && w_pop) r_sent <= r_sent + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base   <= base_addr;
            r_len    <= len;
            r_issued <= '0;
            r_sent   <= '0;
            if (len != '0) r_state <= S_FETCH;
            else           r_done  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            r_issued <= r_issued + CNT_W'(1);
            if (r_issued == r_len - CNT_W'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && (r_sent == r_len - CNT_W'(1))) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // SRAM data is only meaningful the cycle after a chip-select.
  param_fetch_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_din   (mem_R_data),
    .i_pop   (out_ready),
    .o_valid (w_fvalid),
    .o_data  (w_fdata),
    .o_cnt   (w_fcnt)
  );
endmodule

// File: doc/param_fetch.md
# param_fetch

Sequential read engine that sits directly downstream of the 16-byte parameter SRAM. On a start command it reads `len` consecutive words from the SRAM, starting at `base_addr`, and presents them on a valid/ready stream to the compute datapath. The SRAM's one-cycle registered read latency is absorbed by a 2-entry output FIFO with credit-based issue, so the stream can run at one word per cycle under arbitrary backpressure. The block never writes the SRAM.

## Interface
- `ADDR_W`, 32: SRAM address width.
- `DATA_W`, 32: SRAM/stream word width.
- `CNT_W`, 16: width of the `len` field.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; accepted only in IDLE.
- `base_addr`  in  ADDR_W  first read address; sampled with `start`.
- `len`  in  CNT_W  word count; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `mem_cs`  out  1  SRAM chip select; high only on read-issue cycles.
- `mem_oe`  out  1  SRAM output enable; high whenever `busy`.
- `mem_W_req`  out  1  SRAM write strobe, active-low; constant 1 (read only).
- `mem_addr`  out  ADDR_W  SRAM read address.
- `mem_W_data`  out  DATA_W  constant 0.
- `mem_R_data`  in  DATA_W  SRAM read data; valid the cycle after an issue.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  stream consumer ready.
- `out_data`  out  DATA_W  stream word.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: `start` latches `base_addr` and `len` and clears `issued` and `sent`. If `len != 0` the FSM enters FETCH. If `len == 0` it stays in IDLE and pulses `done` on the next cycle; no SRAM access occurs.
- FETCH: issue a read (`mem_cs=1`, `mem_addr = base + issued`, `issued++`) when `issued < len` and `occ < 2 || pop`.
  - `occ` = FIFO entries + read in flight (issued on the previous cycle).
  - `pop` = `out_valid && out_ready`.
  - When the last read has been issued, the FSM enters DRAIN.
- DRAIN: count `sent` on each pop. When the pop with `sent == len-1` occurs, the FSM goes to IDLE and `done` pulses on the following cycle.
- Capture: `mem_R_data` is written into the FIFO only in the cycle after an issue. The SRAM holds stale data on non-CS cycles, so no other cycle captures.
- FIFO: 2 entries. Push and pop in the same cycle are legal at any occupancy, including full (when full, the pop frees the slot). The FIFO cannot overflow because of the credit rule.
- Address arithmetic: `base + issued`, modulo 2^ADDR_W. Wrap-around is silent, and the SRAM's own modulo-depth aliasing is not checked.
- `start` while busy is ignored.
- Reset asserted mid-transfer: the FSM returns to IDLE, the FIFO is flushed, and no `done` is produced.
- Reset values: `busy=0`, `done=0`, `mem_cs=0`, `mem_oe=0`, `mem_W_req=1`, `mem_addr=0`, `mem_W_data=0`, `out_valid=0`, `out_data=0`.

## Timing
- Cycle 0: `start` accepted.
- Cycle 1: `busy=1`, first issue at `base_addr`.
- Cycle 2: data on `mem_R_data`.
- Cycle 3: first `out_valid`.
- With `out_ready` held high, words flow 1/cycle, and the last word is valid in cycle `len+2`.
- `done` is asserted the cycle after the last pop, with `busy` falling in the same cycle.
- `out_data` remains stable while `out_valid && !out_ready`.
- At most 2 words are outstanding (in flight plus buffered) at any time.

## Structure
- `param_fetch_pkg`: `state_e` (IDLE/FETCH/DRAIN) and the FIFO depth constant `FIFO_DEPTH = 2`.
- Sub-module `param_fetch_fifo`: a 2-entry synchronous FIFO with registered outputs, instantiated once.
- The top level holds the FSM, the counters, the credit logic and the SRAM drive.
- At integration, the top level is wired to the SRAM interface's `cs`, `oe`, `W_req`, `addr`, `W_data` and `R_data`.

## Test plan
- Preload the SRAM with {A0,A1,A2,A3}; send `start`, base 0, len 4, with `out_ready=1` -> A0..A3 appear on cycles 3..6, `done` pulses on cycle 7, and exactly 4 `mem_cs` cycles occur.
- Same load with `out_ready` toggling 1,0,0,1 repeatedly -> the order is A0..A3 with no duplicates or drops, `out_data` is stable while stalled, and `occ` never exceeds 2.
- Base 2, len 4, with a 2-bit-deep SRAM model -> the reads go to addresses 2,3,4,5 (aliasing to 2,3,0,1) and the stream is A2,A3,A0,A1.
- len 0 -> no `mem_cs`, `busy` stays 0, and `done` pulses on cycle 1.
- A second `start` pulsed during busy -> it is ignored and only the first transfer completes.
- `rst_n` asserted after 2 words -> all outputs take their reset values immediately, no `done` is produced, and a new `start` then fetches correctly.
